// File: rtl/hotone_pkg.sv
// Shared types and helpers for the classifier output sequencer.
package hotone_pkg;

    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        COLLECT,
        LAUNCH,
        WAIT,
        RESULT
    } state_t;

    // Lowest set bit wins; an all-zero vector maps to 4'hF.
    function automatic logic [3:0] onehot_to_index(input logic [NUM_CLASSES-1:0] onehot);
        logic [3:0] idx;
        idx = 4'hF;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (onehot[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hotone_frame_sequencer.sv
// Collects 10 scores, launches the hot-one encoder, returns its result. Launch 1 cycle after last beat, result 1 cycle after encoder valid.
// score_ready is low from launch until the result handshake; result holds until result_ready.
module hotone_frame_sequencer
    import hotone_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   score_valid,
    output logic                   score_ready,
    input  logic [31:0]            score_data,
    input  logic                   score_last,
    output logic                   enc_input_valid,
    output logic [31:0]            enc_d_in [NUM_CLASSES-1:0],
    input  logic                   enc_output_valid,
    input  logic [NUM_CLASSES-1:0] enc_d_out,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [NUM_CLASSES-1:0] result_onehot,
    output logic [3:0]             result_index,
    output logic                   err_frame,
    output logic                   err_timeout,
    output logic [CNT_W-1:0]       frame_count
);

    localparam int BEAT_W = $clog2(NUM_CLASSES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CLASSES - 1);

    state_t                   r_state;
    logic [BEAT_W-1:0]        r_beat;
    logic [TMO_W-1:0]         r_tmo;
    logic [31:0]              r_enc_d_in [NUM_CLASSES-1:0];
    logic                     r_enc_input_valid;
    logic                     r_result_valid;
    logic [NUM_CLASSES-1:0]   r_result_onehot;
    logic [3:0]               r_result_index;
    logic                     r_err_frame;
    logic                     r_err_timeout;
    logic [CNT_W-1:0]         r_frame_count;
    logic                     w_score_fire;

    assign score_ready     = (r_state == COLLECT) && !rst;
    assign w_score_fire    = score_valid && score_ready;
    assign enc_input_valid = r_enc_input_valid;
    assign enc_d_in        = r_enc_d_in;
    assign result_valid    = r_result_valid;
    assign result_onehot   = r_result_onehot;
    assign result_index    = r_result_index;
    assign err_frame       = r_err_frame;
    assign err_timeout     = r_err_timeout;
    assign frame_count     = r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= COLLECT;
            r_beat            <= '0;
            r_tmo             <= '0;
            r_enc_input_valid <= 1'b0;
            r_result_valid    <= 1'b0;
            r_result_onehot   <= '0;
            r_result_index    <= '0;
            r_err_frame       <= 1'b0;
            r_err_timeout     <= 1'b0;
            r_frame_count     <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) r_enc_d_in[i] <= '0;
        end else begin
            r_enc_input_valid <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_score_fire) begin
                        r_enc_d_in[r_beat] <= score_data;
                        if (r_beat == LAST_BEAT) begin
                            // A missing last on the final beat is flagged but the frame still goes out.
                            if (!score_last) r_err_frame <= 1'b1;
                            r_beat            <= '0;
                            r_enc_input_valid <= 1'b1;
                            r_state           <= LAUNCH;
                        end else if (score_last) begin
                            r_err_frame <= 1'b1;
                            r_beat      <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    r_tmo   <= TMO_W'(TIMEOUT_CYCLES);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (enc_output_valid) begin
                        r_result_onehot <= enc_d_out;
                        r_result_index  <= onehot_to_index(enc_d_out);
                        r_result_valid  <= 1'b1;
                        r_state         <= RESULT;
                    end else if (r_tmo < TMO_W'(2)) begin
                        r_err_timeout   <= 1'b1;
                        r_result_onehot <= '0;
                        r_result_index  <= 4'hF;
                        r_result_valid  <= 1'b1;
                        r_state         <= RESULT;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        r_frame_count  <= r_frame_count + 1'b1;
                        r_result_valid <= 1'b0;
                        r_beat         <= '0;
                        r_state        <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_hotone_frame_sequencer.sv
// Bench for hotone_frame_sequencer: directed scenarios plus randomized frames against a transaction-level model.
module tb_hotone_frame_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        score_valid;
    logic        score_ready;
    logic [31:0] score_data;
    logic        score_last;
    logic        enc_input_valid;
    logic [31:0] enc_d_in [9:0];
    logic        enc_output_valid;
    logic [9:0]  enc_d_out;
    logic        result_valid;
    logic        result_ready;
    logic [9:0]  result_onehot;
    logic [3:0]  result_index;
    logic        err_frame;
    logic        err_timeout;
    logic [15:0] frame_count;

    hotone_frame_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .score_valid(score_valid), .score_ready(score_ready),
        .score_data(score_data), .score_last(score_last),
        .enc_input_valid(enc_input_valid), .enc_d_in(enc_d_in),
        .enc_output_valid(enc_output_valid), .enc_d_out(enc_d_out),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_onehot(result_onehot), .result_index(result_index),
        .err_frame(err_frame), .err_timeout(err_timeout),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus configuration for the next frame's encoder behaviour
    int          cfg_lat = 1;
    logic [9:0]  cfg_val = '0;
    int          rr_mode = 0;
    logic [31:0] frm [10];

    // Model state
    int          cyc = 0;
    bit          rst_prev = 1'b1;
    bit          m_busy = 1'b0;
    int          m_beat = 0;
    logic [31:0] m_frame [10];
    logic [31:0] m_frame_exp [10];
    int          m_launch_at = -100;
    int          m_res_at = -100;
    bit          m_res_vld = 1'b0;
    bit          m_tmo = 1'b0;
    logic [9:0]  m_exp_oh = '0;
    logic [3:0]  m_exp_idx = '0;
    bit          m_err_frame = 1'b0;
    bit          m_err_tmo = 1'b0;
    logic [15:0] m_count = '0;

    // Observations used by the hand-computed expectations
    int          n_launch = 0;
    int          obs_launch_cyc = 0;
    int          obs_lat = 0;
    logic [9:0]  obs_oh = '0;
    logic [3:0]  obs_idx = '0;
    bit          prev_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    function automatic logic [3:0] low_index(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
        return 4'hF;
    endfunction

    // Encoder stand-in: answers cfg_lat cycles after the launch pulse (0 = never).
    int pend = 0;
    initial begin
        enc_output_valid = 1'b0;
        enc_d_out = '0;
        forever begin
            @(posedge clk); #1;
            enc_output_valid = 1'b0;
            enc_d_out = 10'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    enc_output_valid = 1'b1;
                    enc_d_out = cfg_val;
                end
            end
            if (enc_input_valid) pend = cfg_lat;
        end
    end

    initial begin
        result_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       result_ready = 1'b1;
                1:       result_ready = 1'($urandom_range(0, 1));
                default: result_ready = 1'b0;
            endcase
        end
    end

    // Compare process: outputs of the current cycle against the model, then advance the model.
    always @(negedge clk) begin
        int c;
        c = cyc;
        if (rst) check("score_ready_rst", {31'd0, score_ready}, 32'd0);
        else     check("score_ready", {31'd0, score_ready}, {31'd0, !m_busy});
        check("enc_input_valid", {31'd0, enc_input_valid}, {31'd0, c == m_launch_at});
        if (c == m_launch_at)
            for (int i = 0; i < 10; i++) check("enc_d_in", enc_d_in[i], m_frame_exp[i]);
        check("result_valid", {31'd0, result_valid}, {31'd0, m_res_vld});
        if (m_res_vld) begin
            check("result_onehot", {22'd0, result_onehot}, {22'd0, m_exp_oh});
            check("result_index", {28'd0, result_index}, {28'd0, m_exp_idx});
        end
        check("err_frame", {31'd0, err_frame}, {31'd0, m_err_frame});
        check("err_timeout", {31'd0, err_timeout}, {31'd0, m_err_tmo});
        check("frame_count", {16'd0, frame_count}, {16'd0, m_count});
        if (rst_prev) begin
            check("rst_onehot", {22'd0, result_onehot}, 32'd0);
            check("rst_index", {28'd0, result_index}, 32'd0);
            for (int i = 0; i < 10; i++) check("rst_enc_d_in", enc_d_in[i], 32'd0);
        end

        if (enc_input_valid) begin
            n_launch++;
            obs_launch_cyc = c;
        end
        if (result_valid && !prev_rv) obs_lat = c - obs_launch_cyc;
        if (result_valid && result_ready) begin
            obs_oh  = result_onehot;
            obs_idx = result_index;
        end
        prev_rv = result_valid;

        if (rst) begin
            m_busy = 1'b0; m_beat = 0; m_launch_at = -100; m_res_at = -100;
            m_res_vld = 1'b0; m_tmo = 1'b0; m_err_frame = 1'b0; m_err_tmo = 1'b0; m_count = '0;
        end else begin
            if (!m_busy && score_valid) begin
                m_frame[m_beat] = score_data;
                if (m_beat == 9) begin
                    if (!score_last) m_err_frame = 1'b1;
                    m_frame_exp = m_frame;
                    m_beat = 0;
                    m_busy = 1'b1;
                    m_launch_at = c + 1;
                    if (cfg_lat >= 1 && cfg_lat <= TMO) begin
                        m_res_at = c + 2 + cfg_lat;
                        m_exp_oh = cfg_val;
                        m_exp_idx = low_index(cfg_val);
                        m_tmo = 1'b0;
                    end else begin
                        m_res_at = c + 2 + TMO;
                        m_exp_oh = '0;
                        m_exp_idx = 4'hF;
                        m_tmo = 1'b1;
                    end
                end else if (score_last) begin
                    m_err_frame = 1'b1;
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (m_res_vld && result_ready) begin
                m_count = m_count + 16'd1;
                m_res_vld = 1'b0;
                m_busy = 1'b0;
            end
            if (c + 1 == m_res_at) begin
                m_res_vld = 1'b1;
                if (m_tmo) m_err_tmo = 1'b1;
            end
        end
        rst_prev = rst;
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Sends beats frm[0..n-1], raising score_last on beat last_pos (-1 = never).
    task automatic send_frame(input int n, input int last_pos);
        for (int b = 0; b < n; b++) begin
            int  guard;
            bit  acc;
            if ($urandom_range(0, 3) == 0) begin
                score_valid = 1'b0;
                score_data  = $urandom;
                score_last  = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) tick();
            end
            score_valid = 1'b1;
            score_data  = frm[b];
            score_last  = (b == last_pos);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 300) begin
                @(negedge clk);
                acc = score_ready;
                tick();
                guard++;
            end
            if (!acc) bound_fail("send_beat");
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_busy && guard < 400) begin
            tick();
            guard++;
        end
        if (m_busy) bound_fail("wait_idle");
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        score_valid = 1'b0;
        score_data = '0;
        score_last = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: single clean frame, encoder answers after 3 cycles
        frm = '{32'd5, 32'd9, 32'd3, 32'd100, 32'd7, 32'd0, 32'd2, 32'd1, 32'd8, 32'd4};
        cfg_lat = 3; cfg_val = 10'b0000001000; rr_mode = 0;
        send_frame(10, 9);
        wait_idle();
        check("t1_onehot", {22'd0, obs_oh}, 32'h008);
        check("t1_index", {28'd0, obs_idx}, 32'd3);
        check("t1_latency", obs_lat, 32'd4);
        check("t1_count", {16'd0, frame_count}, 32'd1);
        check("t1_errs", {30'd0, err_frame, err_timeout}, 32'd0);

        // 2: two back-to-back frames
        cfg_lat = 1; cfg_val = 10'b0100000000;
        for (int i = 0; i < 10; i++) frm[i] = $urandom;
        send_frame(10, 9);
        send_frame(10, 9);
        wait_idle();
        check("t2_count", {16'd0, frame_count}, 32'd3);
        check("t2_index", {28'd0, obs_idx}, 32'd8);

        // 3: early last on beat 4 drops the frame, then a clean one
        send_frame(5, 4);
        repeat (5) tick();
        check("t3_err_frame", {31'd0, err_frame}, 32'd1);
        check("t3_no_launch", n_launch, 32'd3);
        cfg_lat = 5; cfg_val = 10'b0000100000;
        send_frame(10, 9);
        wait_idle();
        check("t3_index", {28'd0, obs_idx}, 32'd5);
        check("t3_count", {16'd0, frame_count}, 32'd4);

        // 4: encoder silent -> timeout
        cfg_lat = 0;
        send_frame(10, 9);
        wait_idle();
        check("t4_latency", obs_lat, 32'd17);
        check("t4_onehot", {22'd0, obs_oh}, 32'd0);
        check("t4_index", {28'd0, obs_idx}, 32'hF);
        check("t4_err_timeout", {31'd0, err_timeout}, 32'd1);
        check("t4_count", {16'd0, frame_count}, 32'd5);

        // 5: result held under backpressure for 20 cycles
        cfg_lat = 2; cfg_val = 10'b0000000001; rr_mode = 2;
        send_frame(10, 9);
        begin
            int guard;
            guard = 0;
            while (!result_valid && guard < 100) begin tick(); guard++; end
            if (!result_valid) bound_fail("t5_result_valid");
        end
        repeat (20) tick();
        check("t5_held_valid", {31'd0, result_valid}, 32'd1);
        check("t5_held_ready", {31'd0, score_ready}, 32'd0);
        check("t5_held_count", {16'd0, frame_count}, 32'd5);
        rr_mode = 0;
        wait_idle();
        repeat (3) tick();
        check("t5_count", {16'd0, frame_count}, 32'd6);
        check("t5_index", {28'd0, obs_idx}, 32'd0);

        // 6: reset mid-frame, then a frame whose class is 9
        frm = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd1000};
        send_frame(6, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6_count_rst", {16'd0, frame_count}, 32'd0);
        check("t6_errs_rst", {30'd0, err_frame, err_timeout}, 32'd0);
        cfg_lat = 4; cfg_val = 10'b1000000000;
        send_frame(10, 9);
        wait_idle();
        check("t6_index", {28'd0, obs_idx}, 32'd9);
        check("t6_count", {16'd0, frame_count}, 32'd1);

        // Randomized frames: latencies, late/missing responses, framing errors, backpressure
        for (int f = 0; f < 40; f++) begin
            int r;
            int e;
            rr_mode = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0)      cfg_lat = 0;
            else if (r == 1) cfg_lat = $urandom_range(17, 20);
            else             cfg_lat = $urandom_range(1, 16);
            r = $urandom_range(0, 9);
            if (r == 0)      cfg_val = '0;
            else if (r == 1) cfg_val = 10'($urandom);
            else             cfg_val = 10'(1 << $urandom_range(0, 9));
            for (int i = 0; i < 10; i++) frm[i] = $urandom;
            e = $urandom_range(0, 7);
            if (e == 0) begin
                int pos;
                pos = $urandom_range(0, 8);
                send_frame(pos + 1, pos);
            end else if (e == 1) begin
                send_frame(10, -1);
                wait_idle();
            end else begin
                send_frame(10, 9);
                wait_idle();
            end
        end
        rr_mode = 0;
        repeat (25) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hotone_frame_sequencer.md
Name: hotone_frame_sequencer

Overview:
- Sequences the hot-one encoder for the classifier output stage.
- Accepts 10 class scores serially, one 32-bit score per handshake, from the final dense-layer accumulator.
- Packs the scores into a frame, issues a one-cycle launch to the encoder, then waits for its output_valid.
- Returns the one-hot vector and its binary index on a ready/valid result port, with timeout and framing-error detection.

Parameters:
- NUM_CLASSES, 10, scores per frame; fixed to match the encoder width, and any other value is illegal.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for enc_output_valid after launch.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- score_valid  in  1  score beat valid
- score_ready  out  1  sequencer can accept a score beat
- score_data  in  32  class score, treated as an opaque 32-bit value
- score_last  in  1  marks the final beat of a frame
- enc_input_valid  out  1  one-cycle launch pulse to the encoder
- enc_d_in  out  32 x 10 (unpacked [31:0] x [9:0])  frame scores, index 0 = first beat
- enc_output_valid  in  1  encoder result valid
- enc_d_out  in  10  encoder one-hot result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- result_onehot  out  10  one-hot class
- result_index  out  4  binary index of the set bit, 0..9
- err_frame  out  1  sticky: score_last arrived on the wrong beat
- err_timeout  out  1  sticky: encoder did not respond in time
- frame_count  out  CNT_W  frames delivered on the result port

Behaviour:
- Reset:
  - Synchronous: only rst sampled high at a clk edge resets the block.
  - Every output goes to 0 and enc_d_in to all zeros.
  - FSM goes to COLLECT with beat counter 0.
  - A reset mid-frame discards the partial frame; a pending result is lost.
- COLLECT:
  - score_ready = 1.
  - On score_valid & score_ready, score_data is written to enc_d_in[beat] and beat increments.
  - On beat 9 (the 10th accepted beat), score_last must be 1:
    - If it is, go to LAUNCH.
    - If it is not, set err_frame and go to LAUNCH anyway (the frame is processed; a later stray last is handled by the next rule).
  - score_last = 1 on beats 0..8: set err_frame, drop the partial frame, reset beat to 0, stay in COLLECT.
- LAUNCH:
  - score_ready = 0.
  - enc_input_valid = 1 for exactly this one cycle.
  - Load the timeout counter with TIMEOUT_CYCLES.
  - Next state is WAIT.
- WAIT:
  - score_ready = 0.
  - The timeout counter decrements each cycle.
  - If enc_output_valid = 1, capture enc_d_out into result_onehot, compute result_index, and go to RESULT.
  - If the counter reaches 0 with no enc_output_valid:
    - Set err_timeout.
    - Load result_onehot = 0 and result_index = 4'hF.
    - Go to RESULT.
  - enc_output_valid arriving outside WAIT is ignored.
- RESULT:
  - result_valid = 1; result_onehot and result_index stay stable until the handshake.
  - On result_ready = 1: increment frame_count, which wraps at 2^CNT_W - 1 -> 0.
  - On the same cycle: drop result_valid, reset beat to 0, and go to COLLECT.
  - result_ready is don't-care while result_valid = 0.
- Index encoding:
  - result_index is the position of the lowest set bit of enc_d_out.
  - enc_d_out = 0 gives 4'hF.
  - More than one set bit is not expected; if it occurs, the lowest bit wins.
- Latency:
  - Last score accepted at cycle T -> enc_input_valid at T+1.
  - Encoder response at T+1+L (L = encoder latency) -> result_valid at T+2+L.
  - score_ready returns 1 on the cycle after the result handshake.
- Sticky errors: err_frame and err_timeout clear only on rst.
- enc_d_in: holds its value outside COLLECT writes, so the encoder's stage-1 capture sees a stable frame.

Decomposition:
- Package hotone_pkg holds:
  - NUM_CLASSES = 10
  - the state enum {COLLECT, LAUNCH, WAIT, RESULT}
  - the function onehot_to_index(logic [9:0]) returning logic [3:0], with 4'hF for zero.
- No sub-module. The encoder is instantiated beside this block at the parent level, not inside it.

Test Plan:
1. Scores 5,9,3,100,7,0,2,1,8,4 with last on beat 9, encoder model returning 10'b0000001000 after 3 cycles -> result_onehot = 0x008, result_index = 3, frame_count = 1, no errors.
2. Two back-to-back frames with result_ready held 1 -> both results delivered, frame_count = 2, score_ready low only from LAUNCH through RESULT.
3. score_last on beat 4 -> err_frame = 1, no enc_input_valid pulse. The next clean 10-beat frame is processed normally.
4. Encoder model never responds, TIMEOUT_CYCLES = 16 -> result_valid 17 cycles after launch, result_onehot = 0, result_index = 0xF, err_timeout = 1.
5. result_ready held 0 for 20 cycles in RESULT -> outputs stable, score_ready = 0. Then assert ready -> single handshake, frame_count increments once.
6. rst asserted after 6 beats -> all outputs 0, beat = 0. The next full frame produces the correct index (e.g., max at beat 9 -> result_index = 9).
